// File: rtl/down_counter.sv
// down_counter: free-running binary down counter with synchronous load and async active-low reset
module down_counter #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldvalue,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_nxt;
  always_comb w_nxt = ld ? ldvalue : r_cnt - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= RST_VAL;
    else      r_cnt <= w_nxt;
  assign dout = r_cnt;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed checks of reset, load, wrap, load priority and async reset
module tb_down_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic [3:0] ldvalue = 4'h0;
  logic [3:0] dout;
  logic [3:0] exp_v;
  int total = 0;
  int bad = 0;
  down_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .ld(ld), .ldvalue(ldvalue), .dout(dout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [3:0] v, input string tag);
    ld = 1'b1;
    ldvalue = v;
    @(negedge clk);
    chk(tag, dout, v);
    ld = 1'b0;
  endtask
  initial begin
    #1 rst = 1'b0;
    #1 chk("rst_pre_edge", dout, 4'h0);
    ld = 1'b1;
    ldvalue = 4'h6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold", dout, 4'h0);
    end
    ld = 1'b0;
    rst = 1'b1;
    exp_v = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = exp_v - 4'h1;
      chk("rst_release", dout, exp_v);
    end
    load(4'h9, "load9");
    exp_v = 4'h9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_v = exp_v - 4'h1;
      chk("count9", dout, exp_v);
    end
    load(4'h1, "load1");
    @(negedge clk) chk("wrap_0", dout, 4'h0);
    @(negedge clk) chk("wrap_f", dout, 4'hF);
    @(negedge clk) chk("wrap_e", dout, 4'hE);
    load(4'h0, "load0");
    @(negedge clk) chk("load0_wrap", dout, 4'hF);
    load(4'h5, "load5");
    ld = 1'b1;
    ldvalue = 4'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ld_priority", dout, 4'hC);
    end
    ldvalue = 4'h3;
    @(negedge clk) chk("ld_track", dout, 4'h3);
    ld = 1'b0;
    load(4'hA, "loadA");
    @(negedge clk) chk("mid_9", dout, 4'h9);
    @(negedge clk) chk("mid_8", dout, 4'h8);
    @(negedge clk) chk("mid_7", dout, 4'h7);
    #2 rst = 1'b0;
    #1 chk("async_rst", dout, 4'h0);
    ld = 1'b1;
    ldvalue = 4'hB;
    @(negedge clk) chk("async_hold", dout, 4'h0);
    ld = 1'b0;
    rst = 1'b1;
    @(negedge clk) chk("rel_f", dout, 4'hF);
    @(negedge clk) chk("rel_e", dout, 4'hE);
    for (int n = 0; n < 5; n++) begin
      #50;
      @(negedge clk);
      exp_v = 4'($urandom_range(0, 15));
      load(exp_v, "rand_load");
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        exp_v = exp_v - 4'h1;
        chk("rand_count", dout, exp_v);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
